// File: rtl/neo_pixel_decoder_pkg.sv
// Shared timing defaults, pixel word layout and decoder state encoding for the
// NeoPixel receive-side decoder.
package neo_pkg;

    localparam int NUM_PIXELS_DEF = 8;
    localparam int BIT_THRESH_DEF = 27;
    localparam int MIN_HIGH_DEF   = 8;
    localparam int MAX_HIGH_DEF   = 50;
    localparam int MAX_LOW_DEF    = 60;
    localparam int RESET_CYC_DEF  = 2500;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic [2:0] {
        ST_RESYNC = 3'd0,
        ST_IDLE   = 3'd1,
        ST_HIGH   = 3'd2,
        ST_LOW    = 3'd3,
        ST_ERR    = 3'd4
    } dec_state_t;

endpackage

// File: rtl/neo_pixel_decoder_if.sv
// Decoded-pixel output bundle of the NeoPixel decoder plus its FSM state for
// checkers. The decoder drives (master), consumers observe (slave).
interface neo_pixel_decoder_if #(
    parameter int NUM_PIXELS = 8
);
    import neo_pkg::*;

    localparam int IDX_W = $clog2(NUM_PIXELS);
    localparam int WC_W  = $clog2(NUM_PIXELS + 1);

    // pixel_valid / frame_done are single-cycle qualifiers with no back-pressure:
    // the consumer must take pixel_index/pixel_grb or pixel_count/overflow/
    // timing_error in the cycle the pulse is high.
    logic             pixel_valid;
    logic [IDX_W-1:0] pixel_index;
    pixel_t           pixel_grb;
    logic             frame_done;
    logic [WC_W-1:0]  pixel_count;
    logic             overflow;
    logic             timing_error;
    dec_state_t       dbg_state;

    modport master (
        output pixel_valid, pixel_index, pixel_grb, frame_done,
               pixel_count, overflow, timing_error, dbg_state
    );

    modport slave (
        input  pixel_valid, pixel_index, pixel_grb, frame_done,
               pixel_count, overflow, timing_error, dbg_state
    );

endinterface

// File: rtl/neo_pixel_decoder_pulse_meter.sv
// Synchronises the asynchronous neo_data line and measures the width of each
// high and low run in clock cycles, flagging rising and falling edges.
module neo_pulse_meter #(
    parameter int MAX_HIGH  = 50,
    parameter int RESET_CYC = 2500,
    parameter int CNT_W     = 12
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             neo_data,
    output logic             line,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] hi_width,
    output logic [CNT_W-1:0] lo_width
);

    localparam logic [CNT_W-1:0] HI_SAT = CNT_W'(MAX_HIGH + 1);
    localparam logic [CNT_W-1:0] LO_SAT = CNT_W'(RESET_CYC);

    logic [1:0]       sync_q, sync_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] lo_cnt_q, lo_cnt_d;

    // On an edge cycle the counter of the finished run still holds its length,
    // so hi_width is the pulse width when fall_pulse is high (likewise lo_width).
    always_comb begin
        sync_d   = {sync_q[0], neo_data};
        prev_d   = sync_q[1];
        hi_cnt_d = hi_cnt_q;
        lo_cnt_d = lo_cnt_q;
        if (sync_q[1]) begin
            if (!prev_q) begin
                hi_cnt_d = CNT_W'(1);
            end else if (hi_cnt_q < HI_SAT) begin
                hi_cnt_d = hi_cnt_q + 1'b1;
            end
        end else begin
            if (prev_q) begin
                lo_cnt_d = CNT_W'(1);
            end else if (lo_cnt_q < LO_SAT) begin
                lo_cnt_d = lo_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            prev_q   <= 1'b0;
            hi_cnt_q <= '0;
            lo_cnt_q <= '0;
        end else begin
            sync_q   <= sync_d;
            prev_q   <= prev_d;
            hi_cnt_q <= hi_cnt_d;
            lo_cnt_q <= lo_cnt_d;
        end
    end

    assign line       = sync_q[1];
    assign rise_pulse = sync_q[1] & ~prev_q;
    assign fall_pulse = ~sync_q[1] & prev_q;
    assign hi_width   = hi_cnt_q;
    assign lo_width   = lo_cnt_q;

endmodule

// File: rtl/neo_pixel_decoder.sv
// NeoPixel receive-side decoder: turns measured high/low pulse widths into
// 24-bit GRB words, tracks frame position and reports latch gaps and errors.
module neo_pixel_decoder
    import neo_pkg::*;
#(
    parameter int NUM_PIXELS = NUM_PIXELS_DEF,
    parameter int BIT_THRESH = BIT_THRESH_DEF,
    parameter int MIN_HIGH   = MIN_HIGH_DEF,
    parameter int MAX_HIGH   = MAX_HIGH_DEF,
    parameter int MAX_LOW    = MAX_LOW_DEF,
    parameter int RESET_CYC  = RESET_CYC_DEF
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                neo_data,
    neo_pixel_decoder_if.master pix
);

    localparam int IDX_W = $clog2(NUM_PIXELS);
    localparam int WC_W  = $clog2(NUM_PIXELS + 1);
    localparam int TC_W  = $clog2(RESET_CYC + 1);

    localparam logic [TC_W-1:0] T_MIN_HIGH = TC_W'(MIN_HIGH);
    localparam logic [TC_W-1:0] T_MAX_HIGH = TC_W'(MAX_HIGH);
    localparam logic [TC_W-1:0] T_THRESH   = TC_W'(BIT_THRESH);
    localparam logic [TC_W-1:0] T_MAX_LOW  = TC_W'(MAX_LOW);
    localparam logic [TC_W-1:0] T_RESET    = TC_W'(RESET_CYC);
    localparam logic [WC_W-1:0] W_MAX      = WC_W'(NUM_PIXELS);

    logic            line, rise, fall;
    logic [TC_W-1:0] hi_width, lo_width;

    neo_pulse_meter #(
        .MAX_HIGH  (MAX_HIGH),
        .RESET_CYC (RESET_CYC),
        .CNT_W     (TC_W)
    ) u_meter (
        .clock      (clock),
        .reset_n    (reset_n),
        .neo_data   (neo_data),
        .line       (line),
        .rise_pulse (rise),
        .fall_pulse (fall),
        .hi_width   (hi_width),
        .lo_width   (lo_width)
    );

    dec_state_t       state_q, state_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [23:0]      shift_q, shift_d;
    logic [WC_W-1:0]  word_cnt_q, word_cnt_d;
    logic             pixel_valid_q, pixel_valid_d;
    logic [IDX_W-1:0] pixel_index_q, pixel_index_d;
    pixel_t           pixel_grb_q, pixel_grb_d;
    logic             frame_done_q, frame_done_d;
    logic [WC_W-1:0]  pixel_count_q, pixel_count_d;
    logic             overflow_q, overflow_d;
    logic             timing_error_q, timing_error_d;

    logic [23:0] shifted;
    logic        latch;
    logic        long_low;

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        word_cnt_d     = word_cnt_q;
        pixel_valid_d  = 1'b0;
        pixel_index_d  = pixel_index_q;
        pixel_grb_d    = pixel_grb_q;
        frame_done_d   = 1'b0;
        pixel_count_d  = pixel_count_q;
        overflow_d     = frame_done_q ? 1'b0 : overflow_q;
        timing_error_d = frame_done_q ? 1'b0 : timing_error_q;
        latch          = 1'b0;
        shifted        = {shift_q[22:0], (hi_width >= T_THRESH)};
        // lo_width is stale on the falling-edge cycle itself, so exclude it.
        long_low       = !line && !fall && (lo_width == T_RESET);

        unique case (state_q)
            ST_RESYNC: begin
                if (long_low) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (rise) state_d = ST_HIGH;
            end
            ST_HIGH: begin
                if (hi_width > T_MAX_HIGH || (fall && hi_width < T_MIN_HIGH)) begin
                    state_d        = ST_ERR;
                    timing_error_d = 1'b1;
                    bit_cnt_d      = '0;
                end else if (fall) begin
                    shift_d = shifted;
                    state_d = ST_LOW;
                    if (bit_cnt_q == 5'd23) begin
                        bit_cnt_d = '0;
                        if (word_cnt_q < W_MAX) begin
                            pixel_valid_d = 1'b1;
                            pixel_index_d = word_cnt_q[IDX_W-1:0];
                            pixel_grb_d   = shifted;
                            word_cnt_d    = word_cnt_q + 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_LOW: begin
                if (lo_width == T_RESET) begin
                    latch = 1'b1;
                end else if (rise) begin
                    if (lo_width <= T_MAX_LOW) begin
                        state_d = ST_HIGH;
                    end else begin
                        state_d        = ST_ERR;
                        timing_error_d = 1'b1;
                        bit_cnt_d      = '0;
                    end
                end
            end
            ST_ERR: begin
                if (long_low) latch = 1'b1;
            end
            default: state_d = ST_RESYNC;
        endcase

        // A rise on the latch cycle itself already starts the next frame's first bit.
        if (latch) begin
            frame_done_d  = 1'b1;
            pixel_count_d = word_cnt_q;
            if (bit_cnt_d != 5'd0) timing_error_d = 1'b1;
            word_cnt_d    = '0;
            bit_cnt_d     = '0;
            state_d       = rise ? ST_HIGH : ST_IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_RESYNC;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            word_cnt_q     <= '0;
            pixel_valid_q  <= 1'b0;
            pixel_index_q  <= '0;
            pixel_grb_q    <= '0;
            frame_done_q   <= 1'b0;
            pixel_count_q  <= '0;
            overflow_q     <= 1'b0;
            timing_error_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            word_cnt_q     <= word_cnt_d;
            pixel_valid_q  <= pixel_valid_d;
            pixel_index_q  <= pixel_index_d;
            pixel_grb_q    <= pixel_grb_d;
            frame_done_q   <= frame_done_d;
            pixel_count_q  <= pixel_count_d;
            overflow_q     <= overflow_d;
            timing_error_q <= timing_error_d;
        end
    end

    assign pix.pixel_valid  = pixel_valid_q;
    assign pix.pixel_index  = pixel_index_q;
    assign pix.pixel_grb    = pixel_grb_q;
    assign pix.frame_done   = frame_done_q;
    assign pix.pixel_count  = pixel_count_q;
    assign pix.overflow     = overflow_q;
    assign pix.timing_error = timing_error_q;
    assign pix.dbg_state    = state_q;

endmodule

// File: tb/tb_neo_pixel_decoder.sv
// Bench for neo_pixel_decoder: randomized pulse trains scored against a
// frame-level model computed from the decoding rules.
module tb_neo_pixel_decoder;
    import neo_pkg::*;

    localparam int NPIX   = 8;
    localparam int BIT_TH = 27;
    localparam int MINH   = 8;
    localparam int MAXH   = 50;
    localparam int MAXL   = 60;
    localparam int GAP    = 2600;

    logic clock    = 1'b0;
    logic reset_n  = 1'b0;
    logic neo_data = 1'b0;

    int total = 0;
    int bad   = 0;

    neo_pixel_decoder_if #(.NUM_PIXELS(NPIX)) pix ();

    neo_pixel_decoder dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .neo_data (neo_data),
        .pix      (pix)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- scoreboard / monitor ----------------
    logic [26:0] exp_q[$];
    int   fd_cnt = 0;
    int   fd_pc  = 0;
    logic fd_ovf = 1'b0;
    logic fd_te  = 1'b0;
    logic post_pending = 1'b0;
    logic post_ovf = 1'b0;
    logic post_te  = 1'b0;

    always @(negedge clock) begin : monitor
        logic [26:0] got;
        logic [26:0] exp_w;
        if (post_pending) begin
            post_ovf     = pix.overflow;
            post_te      = pix.timing_error;
            post_pending = 1'b0;
        end
        if (pix.frame_done) begin
            fd_cnt++;
            fd_pc        = int'(pix.pixel_count);
            fd_ovf       = pix.overflow;
            fd_te        = pix.timing_error;
            post_pending = 1'b1;
        end
        if (pix.pixel_valid) begin
            got   = {pix.pixel_index, pix.pixel_grb};
            exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 27'bx;
            total++;
            assert (got === exp_w) else begin
                bad++;
                $error("FAIL pixel: observed idx/grb=%h expected=%h", got, exp_w);
            end
        end
    end

    task automatic check(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // ---------------- frame building and reference model ----------------
    int   hq[$];
    int   lq[$];
    int   exp_pc;
    logic exp_ovf;
    logic exp_te;

    task automatic add_raw(input int h, input int l);
        hq.push_back(h);
        lq.push_back(l);
    endtask

    task automatic add_bit(input logic b);
        add_raw(b ? int'($urandom_range(50, 27)) : int'($urandom_range(26, 8)),
                int'($urandom_range(60, 8)));
    endtask

    task automatic add_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) add_bit(w[i]);
    endtask

    // Walk the pulses as the wire protocol defines them: classify each high
    // width, collect bits into 24-bit words, stop at the first timing fault.
    task automatic model_frame();
        int          nb;
        int          words;
        logic [23:0] cur;
        logic        err;
        nb = 0; words = 0; cur = '0; err = 1'b0;
        exp_ovf = 1'b0;
        for (int i = 0; i < hq.size(); i++) begin
            if (hq[i] < MINH || hq[i] > MAXH) begin
                err = 1'b1;
                break;
            end
            cur = {cur[22:0], (hq[i] >= BIT_TH)};
            nb++;
            if (nb == 24) begin
                nb = 0;
                if (words < NPIX) begin
                    exp_q.push_back({3'(words), cur});
                    words++;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
            if (i < hq.size() - 1 && lq[i] > MAXL) begin
                err = 1'b1;
                break;
            end
        end
        exp_te = err || (nb != 0);
        exp_pc = words;
    endtask

    // ---------------- drivers ----------------
    task automatic pulse(input int h, input int l);
        neo_data = 1'b1;
        repeat (h) @(negedge clock);
        neo_data = 1'b0;
        repeat (l) @(negedge clock);
    endtask

    task automatic run_frame(input string tag);
        int prev;
        model_frame();
        prev = fd_cnt;
        for (int i = 0; i < hq.size(); i++)
            pulse(hq[i], (i == hq.size() - 1) ? GAP : lq[i]);
        for (int k = 0; k < 200 && fd_cnt == prev; k++) @(negedge clock);
        repeat (3) @(negedge clock);
        check({tag, " frame_done"}, fd_cnt, prev + 1);
        check({tag, " pixel_count"}, fd_pc, exp_pc);
        check({tag, " overflow"}, int'(fd_ovf), int'(exp_ovf));
        check({tag, " timing_error"}, int'(fd_te), int'(exp_te));
        check({tag, " overflow_cleared"}, int'(post_ovf), 0);
        check({tag, " timing_error_cleared"}, int'(post_te), 0);
        check({tag, " words_outstanding"}, exp_q.size(), 0);
        hq.delete();
        lq.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin : stim
        int prev;
        repeat (3) @(negedge clock);
        check("rst pixel_valid", int'(pix.pixel_valid), 0);
        check("rst frame_done", int'(pix.frame_done), 0);
        check("rst pixel_count", int'(pix.pixel_count), 0);
        check("rst pixel_grb", int'(pix.pixel_grb), 0);
        check("rst flags", int'({pix.overflow, pix.timing_error}), 0);
        check("rst state", int'(pix.dbg_state), int'(ST_RESYNC));
        reset_n = 1'b1;
        repeat (GAP) @(negedge clock);
        check("resync done", int'(pix.dbg_state), int'(ST_IDLE));
        check("resync no frame", fd_cnt, 0);

        // Single known word with fixed widths.
        for (int i = 23; i >= 0; i--) begin
            if (i >= 8 && i < 16) add_raw(35, 28);
            else                  add_raw(18, 45);
        end
        run_frame("t1");

        // Nine words: the ninth overflows.
        for (int w = 0; w < 9; w++) add_word(24'($urandom));
        run_frame("t2");

        // Width boundaries 26/27/50 decode, 51 is stuck-high.
        add_raw(26, 20); add_raw(27, 20); add_raw(50, 20); add_raw(51, 20);
        run_frame("t3");

        // Glitch mid-word.
        for (int i = 0; i < 7; i++) add_bit(1'($urandom));
        add_raw(5, 20);
        for (int i = 0; i < 10; i++) add_bit(1'($urandom));
        run_frame("t4");

        // Long low gap after bit 10.
        for (int i = 0; i < 10; i++) add_bit(1'($urandom));
        lq[9] = 100;
        for (int i = 0; i < 14; i++) add_bit(1'($urandom));
        run_frame("t5a");

        // Partial word at latch.
        for (int i = 0; i < 12; i++) add_bit(1'($urandom));
        run_frame("t5b");

        // Random clean frames.
        for (int f = 0; f < 3; f++) begin
            for (int w = 0; w < int'($urandom_range(2, 1)); w++) add_word(24'($urandom));
            run_frame("rand");
        end

        // Reset mid-word: outputs clear at once, rest of the frame is ignored.
        for (int i = 0; i < 12; i++) pulse(int'($urandom_range(50, 8)), int'($urandom_range(60, 8)));
        #2 reset_n = 1'b0;
        #1;
        check("t6 pixel_count", int'(pix.pixel_count), 0);
        check("t6 flags", int'({pix.pixel_valid, pix.frame_done, pix.overflow, pix.timing_error}), 0);
        check("t6 state", int'(pix.dbg_state), int'(ST_RESYNC));
        @(negedge clock);
        reset_n = 1'b1;
        prev = fd_cnt;
        for (int i = 0; i < 30; i++) pulse(int'($urandom_range(50, 8)), int'($urandom_range(60, 8)));
        pulse(30, GAP);
        check("t6 no frame_done", fd_cnt, prev);
        check("t6 resync idle", int'(pix.dbg_state), int'(ST_IDLE));

        add_word(24'($urandom));
        add_word(24'($urandom));
        run_frame("t6 after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
